// File: rtl/ag_pkg.sv
// Shared definitions for the coprocessor serial link: sync byte, opcode
// values and the state encodings of the UART byte receiver and frame parser.
// Build option: AG_RX_PARITY_EN adds an even-parity bit between data and
// stop (8E1); without it the receiver is plain 8N1.
package ag_pkg;

   localparam logic [7:0] SYNC_BYTE   = 8'hA5;

   localparam logic [7:0] OP_SET_CROP = 8'h01;
   localparam logic [7:0] OP_OVERRIDE = 8'h02;
   localparam logic [7:0] OP_PING     = 8'h03;

`ifdef AG_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} byte_state_e;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} byte_state_e;
`endif

   typedef enum logic [1:0] {HUNT, OPC, ARG, CHK} parse_state_e;

endpackage

// File: rtl/ag_uart_byte_rx.sv
// UART byte receiver: baud tick generator, rx synchroniser and byte FSM.
// Build option: AG_RX_PARITY_EN inserts an even-parity state before STOP;
// a parity mismatch is reported on framing_err_o like a bad stop bit.
module ag_uart_byte_rx
   import ag_pkg::*;
#(
   parameter int CLK_HZ     = 25_000_000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena_i,
   input  logic       rx_i,
   output logic       tick_o,
   output logic       byte_valid_o,
   output logic [7:0] byte_data_o,
   output logic       framing_err_o,
   output logic       busy_o
);

   localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
   localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int CW  = $clog2(OVERSAMPLE);
   localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);

   if (DIV < 1) begin : g_div_check
      $error("ag_uart_byte_rx: CLK_HZ too low for BAUD*OVERSAMPLE");
   end
   if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_os_check
      $error("ag_uart_byte_rx: OVERSAMPLE must be even and >= 4");
   end

   logic [DW-1:0] divCnt_q;
   logic          rxMeta_q;
   logic          rxs_q;
   byte_state_e   state_q;
   logic [CW-1:0] tickCnt_q;
   logic [2:0]    bitIdx_q;
   logic [7:0]    shift_q;
   logic          byteValid_q;
   logic          framingErr_q;
   logic          tick;
`ifdef AG_RX_PARITY_EN
   logic          parErr_q;
`endif

   assign tick          = ena_i && (divCnt_q == DIV_LAST);
   assign tick_o        = tick;
   assign byte_valid_o  = byteValid_q;
   assign byte_data_o   = shift_q;
   assign framing_err_o = framingErr_q;
   assign busy_o        = (state_q != IDLE);

   // Free-running oversample tick divider, frozen while disabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         divCnt_q <= '0;
      end else if (ena_i) begin
         divCnt_q <= tick ? '0 : divCnt_q + 1'b1;
      end
   end

   // Two-flop synchroniser on the asynchronous line; keeps running when disabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxMeta_q <= 1'b1;
         rxs_q    <= 1'b1;
      end else begin
         rxMeta_q <= rx_i;
         rxs_q    <= rxMeta_q;
      end
   end

   // Byte FSM: centre-samples start, data and stop bits; result pulses are registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         tickCnt_q    <= '0;
         bitIdx_q     <= '0;
         shift_q      <= '0;
         byteValid_q  <= 1'b0;
         framingErr_q <= 1'b0;
`ifdef AG_RX_PARITY_EN
         parErr_q     <= 1'b0;
`endif
      end else if (ena_i) begin
         byteValid_q  <= 1'b0;
         framingErr_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!rxs_q) begin
                  state_q   <= START;
                  tickCnt_q <= '0;
               end
            end
            START: begin
               if (tick) begin
                  if (tickCnt_q == HALF_LAST) begin
                     tickCnt_q <= '0;
                     bitIdx_q  <= '0;
                     state_q   <= rxs_q ? IDLE : DATA;
                  end else begin
                     tickCnt_q <= tickCnt_q + 1'b1;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  if (tickCnt_q == FULL_LAST) begin
                     tickCnt_q <= '0;
                     shift_q   <= {rxs_q, shift_q[7:1]};
                     bitIdx_q  <= bitIdx_q + 1'b1;
                     if (bitIdx_q == 3'd7) begin
`ifdef AG_RX_PARITY_EN
                        state_q <= PARITY;
`else
                        state_q <= STOP;
`endif
                     end
                  end else begin
                     tickCnt_q <= tickCnt_q + 1'b1;
                  end
               end
            end
`ifdef AG_RX_PARITY_EN
            PARITY: begin
               if (tick) begin
                  if (tickCnt_q == FULL_LAST) begin
                     tickCnt_q <= '0;
                     parErr_q  <= rxs_q ^ (^shift_q);
                     state_q   <= STOP;
                  end else begin
                     tickCnt_q <= tickCnt_q + 1'b1;
                  end
               end
            end
`endif
            STOP: begin
               if (tick) begin
                  if (tickCnt_q == FULL_LAST) begin
                     tickCnt_q <= '0;
                     if (!rxs_q) begin
                        framingErr_q <= 1'b1;
                        state_q      <= BREAK;
`ifdef AG_RX_PARITY_EN
                     end else if (parErr_q) begin
                        framingErr_q <= 1'b1;
                        state_q      <= IDLE;
`endif
                     end else begin
                        byteValid_q <= 1'b1;
                        state_q     <= IDLE;
                     end
                  end else begin
                     tickCnt_q <= tickCnt_q + 1'b1;
                  end
               end
            end
            BREAK: begin
               if (rxs_q) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/ag_uart_cmd_rx.sv
// Command-frame receiver: frames of SYNC, OPC, ARG, CHK are parsed from the
// UART byte stream and delivered as {opcode, arg} over valid/ready.
// Build option: AG_RX_PARITY_EN selects 8E1 framing in the byte receiver.
module ag_uart_cmd_rx
   import ag_pkg::*;
#(
   parameter int CLK_HZ       = 25_000_000,
   parameter int BAUD         = 115200,
   parameter int OVERSAMPLE   = 16,
   parameter int TIMEOUT_BITS = 40
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena_i,
   input  logic       rx_i,
   output logic       cmd_valid_o,
   input  logic       cmd_ready_i,
   output logic [7:0] cmd_opcode_o,
   output logic [7:0] cmd_arg_o,
   output logic       err_framing_o,
   output logic       err_checksum_o,
   output logic       err_timeout_o,
   output logic       err_overrun_o,
   output logic       busy_o
);

   localparam int TO_LIMIT = OVERSAMPLE * TIMEOUT_BITS;
   localparam int TW       = $clog2(TO_LIMIT);
   localparam logic [TW-1:0] TO_LAST = TW'(TO_LIMIT - 1);

   logic         tick;
   logic         byteValid;
   logic [7:0]   byteData;
   logic         framingErr;
   logic         byteBusy;

   parse_state_e pstate_q;
   logic [TW-1:0] toCnt_q;
   logic [7:0]   opc_q;
   logic [7:0]   arg_q;
   logic         cmdValid_q;
   logic [7:0]   cmdOpcode_q;
   logic [7:0]   cmdArg_q;
   logic         errChecksum_q;
   logic         errTimeout_q;
   logic         errOverrun_q;

   ag_uart_byte_rx #(
      .CLK_HZ     (CLK_HZ),
      .BAUD       (BAUD),
      .OVERSAMPLE (OVERSAMPLE)
   ) uByteRx (
      .clk           (clk),
      .rst_n         (rst_n),
      .ena_i         (ena_i),
      .rx_i          (rx_i),
      .tick_o        (tick),
      .byte_valid_o  (byteValid),
      .byte_data_o   (byteData),
      .framing_err_o (framingErr),
      .busy_o        (byteBusy)
   );

   assign cmd_valid_o    = cmdValid_q;
   assign cmd_opcode_o   = cmdOpcode_q;
   assign cmd_arg_o      = cmdArg_q;
   assign err_framing_o  = framingErr & ena_i;
   assign err_checksum_o = errChecksum_q;
   assign err_timeout_o  = errTimeout_q;
   assign err_overrun_o  = errOverrun_q;
   assign busy_o         = (pstate_q != HUNT) | byteBusy;

   // Frame parser, inter-byte timeout and command handshake; error pulses last one cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pstate_q      <= HUNT;
         toCnt_q       <= '0;
         opc_q         <= '0;
         arg_q         <= '0;
         cmdValid_q    <= 1'b0;
         cmdOpcode_q   <= '0;
         cmdArg_q      <= '0;
         errChecksum_q <= 1'b0;
         errTimeout_q  <= 1'b0;
         errOverrun_q  <= 1'b0;
      end else begin
         errChecksum_q <= 1'b0;
         errTimeout_q  <= 1'b0;
         errOverrun_q  <= 1'b0;
         if (ena_i) begin
            if (cmdValid_q && cmd_ready_i) begin
               cmdValid_q <= 1'b0;
            end
            if (byteValid) begin
               toCnt_q <= '0;
               case (pstate_q)
                  HUNT: begin
                     if (byteData == SYNC_BYTE) begin
                        pstate_q <= OPC;
                     end
                  end
                  OPC: begin
                     opc_q    <= byteData;
                     pstate_q <= ARG;
                  end
                  ARG: begin
                     arg_q    <= byteData;
                     pstate_q <= CHK;
                  end
                  CHK: begin
                     pstate_q <= HUNT;
                     if (byteData != (opc_q + arg_q)) begin
                        errChecksum_q <= 1'b1;
                     end else if (cmdValid_q) begin
                        errOverrun_q <= 1'b1;
                     end else begin
                        cmdValid_q  <= 1'b1;
                        cmdOpcode_q <= opc_q;
                        cmdArg_q    <= arg_q;
                     end
                  end
                  default: pstate_q <= HUNT;
               endcase
            end else if (framingErr && (pstate_q != HUNT)) begin
               pstate_q <= HUNT;
            end else if ((pstate_q != HUNT) && tick) begin
               if (toCnt_q == TO_LAST) begin
                  errTimeout_q <= 1'b1;
                  pstate_q     <= HUNT;
               end else begin
                  toCnt_q <= toCnt_q + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ag_uart_cmd_rx.sv
// Self-checking bench for ag_uart_cmd_rx (8N1 build, DIV=1, 16 clocks per bit).
// Expected commands and error events are queued when frames are sent and
// popped by a negedge monitor when the DUT produces them.
module tb_ag_uart_cmd_rx;

   localparam int BIT_CLKS = 16;
   localparam logic [31:0] EV_FRAMING  = 32'd1;
   localparam logic [31:0] EV_CHECKSUM = 32'd2;
   localparam logic [31:0] EV_TIMEOUT  = 32'd3;
   localparam logic [31:0] EV_OVERRUN  = 32'd4;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic       rx;
   logic       cmdValid;
   logic       cmdReady;
   logic [7:0] cmdOpcode;
   logic [7:0] cmdArg;
   logic       errFraming;
   logic       errChecksum;
   logic       errTimeout;
   logic       errOverrun;
   logic       busy;

   int totalChecks = 0;
   int badChecks   = 0;
   int validCycles = 0;
   int byteValids  = 0;
   logic [31:0] cmdQ[$];
   logic [31:0] errQ[$];

   ag_uart_cmd_rx #(
      .CLK_HZ       (1_600_000),
      .BAUD         (100_000),
      .OVERSAMPLE   (16),
      .TIMEOUT_BITS (40)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ena_i          (ena),
      .rx_i           (rx),
      .cmd_valid_o    (cmdValid),
      .cmd_ready_i    (cmdReady),
      .cmd_opcode_o   (cmdOpcode),
      .cmd_arg_o      (cmdArg),
      .err_framing_o  (errFraming),
      .err_checksum_o (errChecksum),
      .err_timeout_o  (errTimeout),
      .err_overrun_o  (errOverrun),
      .busy_o         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      totalChecks++;
      if (observed !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Pop one expected error event and compare it with what the DUT raised
   task automatic popError(input logic [31:0] kind);
      if (errQ.size() == 0) begin
         checkOutput("unexpected error pulse", kind, 32'hFFFF_FFFF);
      end else begin
         checkOutput("error kind", kind, errQ.pop_front());
      end
   endtask

   // Negedge monitor: scoreboard consumer for handshakes and error pulses
   always @(negedge clk) begin
      if (rst_n) begin
         if (cmdValid) validCycles++;
         if (dut.uByteRx.byte_valid_o) byteValids++;
         if (cmdValid && cmdReady) begin
            if (cmdQ.size() == 0) begin
               checkOutput("unexpected command", {16'h0, cmdOpcode, cmdArg}, 32'hFFFF_FFFF);
            end else begin
               checkOutput("command", {16'h0, cmdOpcode, cmdArg}, cmdQ.pop_front());
            end
         end
         if (errFraming)  popError(EV_FRAMING);
         if (errChecksum) popError(EV_CHECKSUM);
         if (errTimeout)  popError(EV_TIMEOUT);
         if (errOverrun)  popError(EV_OVERRUN);
      end
   end

   // Watchdog: the run must never hang
   initial begin
      repeat (60000) @(posedge clk);
      $display("[TB] FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic waitClk(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic sendByte(input logic [7:0] b, input logic stopBit);
      rx = 1'b0;
      waitClk(BIT_CLKS);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         waitClk(BIT_CLKS);
      end
      rx = stopBit;
      waitClk(BIT_CLKS);
      rx = 1'b1;
   endtask

   task automatic applyStimulus(input logic [7:0] opc, input logic [7:0] arg, input logic [7:0] chk);
      sendByte(8'hA5, 1'b1);
      sendByte(opc, 1'b1);
      sendByte(arg, 1'b1);
      sendByte(chk, 1'b1);
      waitClk(30);
   endtask

   task automatic checkQueues(input string tag);
      checkOutput({tag, " cmd queue drained"}, cmdQ.size(), 0);
      checkOutput({tag, " err queue drained"}, errQ.size(), 0);
   endtask

   initial begin
      int v0;
      int b0;
      rst_n = 1'b0;
      ena = 1'b1;
      rx = 1'b1;
      cmdReady = 1'b0;
      waitClk(3);
      checkOutput("reset cmd_valid", cmdValid, 0);
      checkOutput("reset opcode", cmdOpcode, 0);
      checkOutput("reset arg", cmdArg, 0);
      checkOutput("reset errors", {errFraming, errChecksum, errTimeout, errOverrun}, 0);
      checkOutput("reset busy", busy, 0);
      rst_n = 1'b1;
      waitClk(5);

      // Good frame, consumer always ready
      cmdReady = 1'b1;
      v0 = validCycles;
      cmdQ.push_back({16'h0, 8'h01, 8'h02});
      applyStimulus(8'h01, 8'h02, 8'h03);
      checkOutput("good frame valid cycles", validCycles - v0, 1);
      checkOutput("idle busy", busy, 0);
      checkQueues("good");

      // Bad checksum, then a good frame
      errQ.push_back(EV_CHECKSUM);
      applyStimulus(8'h02, 8'h01, 8'h04);
      checkOutput("checksum no valid", cmdValid, 0);
      cmdQ.push_back({16'h0, 8'h03, 8'h00});
      applyStimulus(8'h03, 8'h00, 8'h03);
      checkQueues("checksum");

      // Overrun while the first command is held
      cmdReady = 1'b0;
      cmdQ.push_back({16'h0, 8'h01, 8'h02});
      applyStimulus(8'h01, 8'h02, 8'h03);
      errQ.push_back(EV_OVERRUN);
      applyStimulus(8'h03, 8'h00, 8'h03);
      checkOutput("held valid", cmdValid, 1);
      checkOutput("held command", {cmdOpcode, cmdArg}, 16'h0102);
      cmdReady = 1'b1;
      waitClk(2);
      checkOutput("valid drops after ready", cmdValid, 0);
      checkQueues("overrun");

      // Stop bit low on the OPC byte
      errQ.push_back(EV_FRAMING);
      sendByte(8'hA5, 1'b1);
      sendByte(8'h01, 1'b0);
      waitClk(2 * BIT_CLKS);
      checkOutput("framing parser hunt", busy, 0);
      cmdQ.push_back({16'h0, 8'h01, 8'h02});
      applyStimulus(8'h01, 8'h02, 8'h03);
      checkQueues("framing");

      // Inter-byte timeout, late ARG ignored
      errQ.push_back(EV_TIMEOUT);
      sendByte(8'hA5, 1'b1);
      sendByte(8'h01, 1'b1);
      waitClk(41 * BIT_CLKS);
      sendByte(8'h02, 1'b1);
      waitClk(30);
      checkOutput("timeout no valid", cmdValid, 0);
      checkOutput("timeout busy", busy, 0);
      checkQueues("timeout");

      // Short glitch: no byte, busy returns low
      b0 = byteValids;
      rx = 1'b0;
      waitClk(4);
      rx = 1'b1;
      waitClk(2);
      checkOutput("glitch busy", busy, 1);
      waitClk(30);
      checkOutput("glitch byte count", byteValids - b0, 0);
      checkOutput("glitch idle", busy, 0);

      // Reset in the middle of the ARG byte
      sendByte(8'hA5, 1'b1);
      sendByte(8'h07, 1'b1);
      rx = 1'b0;
      waitClk(5 * BIT_CLKS);
      checkOutput("mid-arg busy", busy, 1);
      rst_n = 1'b0;
      waitClk(2);
      checkOutput("mid reset busy", busy, 0);
      checkOutput("mid reset valid", cmdValid, 0);
      checkOutput("mid reset command", {cmdOpcode, cmdArg}, 0);
      rx = 1'b1;
      rst_n = 1'b1;
      waitClk(3 * BIT_CLKS);
      cmdQ.push_back({16'h0, 8'h03, 8'h00});
      applyStimulus(8'h03, 8'h00, 8'h03);
      checkQueues("after reset");

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule

// File: doc/ag_uart_cmd_rx.md
Name: ag_uart_cmd_rx

Overview:
- Receive side of the coprocessor's serial link: the main processor sends command frames on uio_in[3], and this block, a UART 8N1 receiver plus frame parser, decodes them.
- Delivers validated {opcode, arg} pairs to the control core over a valid/ready handshake.
- Reports framing, checksum, timeout and overrun errors as single-cycle pulses.
- Sits between the top-level pin map and ag_control_core; it is the counterpart of the core's uart_tx.

Parameters:
- CLK_HZ, 25_000_000, system clock frequency in Hz.
- BAUD, 115200, line bit rate.
- OVERSAMPLE, 16, sample ticks per bit; must be even and >= 4.
- TIMEOUT_BITS, 40, maximum gap, in bit times, between bytes inside one frame.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- ena  in  1  global enable; low freezes all state
- rx  in  1  asynchronous serial input, idle high
- cmd_valid  out  1  validated command available
- cmd_ready  in  1  consumer accepts command
- cmd_opcode  out  8  command opcode
- cmd_arg  out  8  command argument
- err_framing  out  1  1-cycle pulse: stop bit sampled low
- err_checksum  out  1  1-cycle pulse: checksum mismatch
- err_timeout  out  1  1-cycle pulse: inter-byte gap exceeded
- err_overrun  out  1  1-cycle pulse: frame dropped because cmd_valid still pending
- busy  out  1  high when the parser is not in HUNT or the byte receiver is not IDLE

Behaviour:
- Reset values: cmd_valid=0, cmd_opcode=0x00, cmd_arg=0x00, all err_*=0, busy=0. Synchroniser flops reset to 1. All FSMs reset to IDLE/HUNT.
- Tick generator:
  - DIV = CLK_HZ/(BAUD*OVERSAMPLE), integer truncation; DIV < 1 is illegal (elaboration error).
  - A 1-cycle tick fires every DIV enabled clocks, free-running.
- rx passes through a 2-flop synchroniser; all logic uses the synchronised rxs.
- Byte FSM:
  - IDLE: rxs=0 → START, tick count cleared.
  - START: after OVERSAMPLE/2 ticks, rxs=1 → IDLE (glitch, no error); otherwise → DATA.
  - DATA: 8 bits, each sampled every OVERSAMPLE ticks, LSB first.
  - STOP: sampled OVERSAMPLE ticks after the last data bit.
    - rxs=1: byte_valid pulses the next cycle; FSM → IDLE.
    - rxs=0: err_framing pulses; byte is discarded; FSM → BREAK.
  - BREAK: wait for rxs=1 → IDLE.
- Frame: 0xA5 (SYNC), OPC, ARG, CHK, where CHK = (OPC + ARG) mod 256.
- Frame parser:
  - HUNT: byte==0xA5 → OPC; any other byte is ignored silently.
  - OPC: store byte → ARG.
  - ARG: store byte → CHK.
  - CHK, match and cmd_valid=0: load cmd_opcode/cmd_arg and set cmd_valid the next cycle (2 cycles after the CHK stop-bit sample).
  - CHK, match and cmd_valid=1: err_overrun pulses; new frame dropped; held command unchanged.
  - CHK, mismatch: err_checksum pulses.
  - All CHK outcomes → HUNT.
  - An err_framing event while in OPC/ARG/CHK forces → HUNT.
- Timeout:
  - A counter restarts on entry to OPC and on each byte_valid.
  - If OVERSAMPLE*TIMEOUT_BITS ticks elapse with no byte_valid while in OPC/ARG/CHK: err_timeout pulses; parser → HUNT.
- Handshake:
  - cmd_valid stays high, and cmd_opcode/cmd_arg stay stable, until a cycle with cmd_valid & cmd_ready; cmd_valid clears on the following edge.
  - cmd_ready is ignored when cmd_valid=0.
  - CHK completing on the same cycle the handshake occurs counts as pending, so it produces an overrun.
- ena=0: all counters, FSMs and outputs hold; err_* pulses are suppressed. The synchroniser keeps running.
- Reset mid-byte or mid-frame: immediate return to reset values; any partial frame is lost.

Optional Feature:
- AG_RX_PARITY_EN defined:
  - An even-parity bit is inserted between DATA and STOP (8E1).
  - A mismatch pulses err_framing alongside a stop-bit error, discards the byte and forces the parser → HUNT.
- Undefined: 8N1; no parity state exists.

Decomposition:
- Package ag_pkg holds:
  - SYNC_BYTE=8'hA5.
  - Opcode constants OP_SET_CROP=8'h01, OP_OVERRIDE=8'h02, OP_PING=8'h03, shared with the future TX and core decoder.
  - Byte FSM enum (IDLE, START, DATA, [PARITY,] STOP, BREAK) and parser enum (HUNT, OPC, ARG, CHK).
- Sub-module ag_uart_byte_rx contains the tick generator, synchroniser and byte FSM. It outputs byte_valid, byte_data[7:0] and framing_err.
- The parent holds the frame parser, timeout counter and handshake.

Test Plan:
All scenarios use CLK_HZ=1_600_000, BAUD=100_000, OVERSAMPLE=16 (DIV=1, 16 clk/bit).
- Frame A5 01 02 03 with cmd_ready=1 → cmd_valid 1 cycle, opcode=0x01, arg=0x02, no err_*.
- Frame A5 02 01 04 (bad CHK, correct is 0x03) → err_checksum 1 cycle, cmd_valid stays 0; a following good frame is then accepted.
- cmd_ready=0, two good frames A5 01 02 03 then A5 03 00 03 → first command held (0x01/0x02), err_overrun on the second CHK; after ready, cmd_valid drops.
- Stop bit forced low on the OPC byte → err_framing; parser in HUNT; a later A5 frame decodes correctly.
- A5 01, then idle 41 bit times → err_timeout; ARG byte 0x02 sent afterwards is ignored.
- 4-clk low glitch on rx → no byte_valid, busy returns to 0; rst_n asserted mid-ARG → all outputs 0, next full frame decodes.
